// File: rtl/ltpi_data_channel_controller_xfer_if.sv
// Purpose: groups the request, link TX, link RX and completion signals of the
//          LTPI data-channel controller transfer block into one bundle.
// Ports:   slave = controller block view, master = requester/link view.
interface ltpi_data_channel_controller_xfer_if #(
  parameter int REQ_WIDTH  = 32,
  parameter int REQ_DEPTH  = 8,
  parameter int RESP_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  localparam int CNT_W = $clog2(REQ_DEPTH) + 1;

  // local request side
  logic [REQ_WIDTH-1:0]  req_data;
  logic                  req_valid;
  logic                  req_ready;
  logic [CNT_W-1:0]      req_count;
  // link TX side
  logic [REQ_WIDTH-1:0]  tx_data;
  logic [TAG_WIDTH-1:0]  tx_tag;
  logic                  tx_valid;
  logic                  tx_ready;
  // link RX side (no backpressure)
  logic [RESP_WIDTH-1:0] rx_data;
  logic [TAG_WIDTH-1:0]  rx_tag;
  logic                  rx_valid;
  // completion side
  logic [RESP_WIDTH-1:0] resp_data;
  logic [1:0]            resp_status;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  err_unexp_tag;

  modport slave (
    input  req_data, req_valid, tx_ready, rx_data, rx_tag, rx_valid, resp_ready,
    output req_ready, req_count, tx_data, tx_tag, tx_valid,
           resp_data, resp_status, resp_valid, err_unexp_tag
  );

  modport master (
    output req_data, req_valid, tx_ready, rx_data, rx_tag, rx_valid, resp_ready,
    input  req_ready, req_count, tx_data, tx_tag, tx_valid,
           resp_data, resp_status, resp_valid, err_unexp_tag
  );
endinterface

// File: rtl/ltpi_data_channel_controller_xfer.sv
// Purpose: controller-side LTPI data-channel initiator; buffers local requests,
//          issues them one at a time with a rolling tag, returns the tagged response
//          or a timeout completion.
// Latency: push->tx_valid 2 cycles from IDLE; matching rx->resp_valid 1 cycle;
//          tx handshake->timeout completion 1+TIMEOUT_CYCLES cycles.
// Backpressure: req_ready low only when the buffer is full; tx held until tx_ready;
//          completion held until resp_ready; rx cannot be stalled.
// Ports: clk, reset (async, active-low), bus (slave modport):
//          req_*  local request FIFO input and fill level
//          tx_*   request offered to the link with its tag
//          rx_*   tagged response strobe from the link
//          resp_* completion (status 00=OK, 01=TIMEOUT) to the local requester
//          err_unexp_tag  one-cycle pulse for any response that is not the awaited one
module ltpi_data_channel_controller_xfer #(
  parameter int REQ_WIDTH      = 32,
  parameter int REQ_DEPTH      = 8,
  parameter int RESP_WIDTH     = 32,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  ltpi_data_channel_controller_xfer_if.slave bus
);

  localparam int PTR_W = $clog2(REQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REQ_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [RESP_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [1:0]            resp_status_q, resp_status_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  err_q, err_d;

  logic [REQ_WIDTH-1:0]  mem_q [REQ_DEPTH];

  logic req_ready;
  logic push;
  logic pop;
  logic rx_match;

  // ---------------------------------------------------------------------------
  // Request buffer (first-word fall-through circular FIFO)
  // ---------------------------------------------------------------------------
  // Full is judged on the registered count only, so a same-cycle pop does not
  // open the buffer for a push.
  assign req_ready = (count_q != CNT_FULL);
  assign push      = bus.req_valid && req_ready;
  // tx_valid_q is high exactly while the FSM sits in SEND.
  assign pop       = tx_valid_q && bus.tx_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset: the pointers define which entries are live, so a
  // reset discards everything simply by clearing them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.req_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------------
  assign rx_match = bus.rx_valid && (state_q == S_WAIT) && (bus.rx_tag == tag_q);

  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    timer_d       = timer_q;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;
    // Any response that is not the awaited one, in any state, is flagged and dropped.
    err_d         = bus.rx_valid && !rx_match;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (bus.tx_ready) begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // A matching response in the last timer cycle takes priority over timeout.
        if (rx_match) begin
          resp_data_d   = bus.rx_data;
          resp_status_d = ST_OK;
          state_d       = S_DONE;
        end else if (timer_q == TMR_LAST) begin
          resp_data_d   = '0;
          resp_status_d = ST_TIMEOUT;
          state_d       = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.resp_ready) begin
          tag_d         = tag_q + TAG_WIDTH'(1);
          resp_data_d   = '0;
          resp_status_d = ST_OK;
          state_d       = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Handshake strobes are registered straight from the next state.
    tx_valid_d   = (state_d == S_SEND);
    resp_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tag_q         <= '0;
      timer_q       <= '0;
      resp_data_q   <= '0;
      resp_status_q <= ST_OK;
      tx_valid_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tag_q         <= tag_d;
      timer_q       <= timer_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
      tx_valid_q    <= tx_valid_d;
      resp_valid_q  <= resp_valid_d;
      err_q         <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready     = req_ready;
  assign bus.req_count     = count_q;
  // Buffer head is only presented while offered, keeping the bus quiet otherwise.
  assign bus.tx_data       = tx_valid_q ? mem_q[rd_ptr_q] : '0;
  assign bus.tx_tag        = tx_valid_q ? tag_q : '0;
  assign bus.tx_valid      = tx_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_status   = resp_status_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.err_unexp_tag = err_q;

endmodule

// File: tb/tb_ltpi_data_channel_controller_xfer.sv
// Purpose: directed self-checking bench for ltpi_data_channel_controller_xfer.
// Latency: expected tx words and completions are queued at stimulus time and
//          checked by a monitor when the DUT hands them over.
// Backpressure: exercises full buffer, tx stall, resp stall and timeout.
module tb_ltpi_data_channel_controller_xfer;

  localparam int TO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  ltpi_data_channel_controller_xfer_if #(
    .REQ_WIDTH(32), .REQ_DEPTH(8), .RESP_WIDTH(32), .TAG_WIDTH(4)
  ) bus ();

  ltpi_data_channel_controller_xfer #(
    .REQ_WIDTH(32), .REQ_DEPTH(8), .RESP_WIDTH(32), .TAG_WIDTH(4),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_tx[$];     // expected tx_data order
  logic [33:0] exp_resp[$];   // {resp_data, resp_status}
  logic [3:0]  model_tag = 4'd0;
  logic [31:0] mon_e;
  logic [33:0] mon_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the falling edge; the monitor samples at +2 ns,
  // seeing current outputs together with the inputs for the next rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    exp_tx.push_back(d);
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_tx();
    int n = 0;
    while (!bus.tx_valid && n < 20) begin
      tick();
      n++;
    end
    chk("tx_wait", bus.tx_valid, 1);
  endtask

  // One complete transfer with tx_ready=1 and resp_ready=1.
  task automatic serve(input logic [31:0] rdata);
    wait_tx();
    tick();
    bus.rx_valid = 1'b1;
    bus.rx_tag   = model_tag;
    bus.rx_data  = rdata;
    exp_resp.push_back({rdata, 2'b00});
    tick();
    bus.rx_valid = 1'b0;
    chk("serve_resp_valid", bus.resp_valid, 1);
    tick();
  endtask

  // Scoreboard monitor.
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0) begin
          chk("tx_unexpected", exp_tx.size(), 1);
        end else begin
          mon_e = exp_tx.pop_front();
          chk("tx_data", bus.tx_data, mon_e);
          chk("tx_tag", bus.tx_tag, model_tag);
        end
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_resp.size() == 0) begin
          chk("resp_unexpected", exp_resp.size(), 1);
        end else begin
          mon_r = exp_resp.pop_front();
          chk("resp_data", bus.resp_data, mon_r[33:2]);
          chk("resp_status", bus.resp_status, mon_r[1:0]);
          model_tag = model_tag + 4'd1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_data   = '0;
    bus.tx_ready   = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = '0;
    bus.rx_tag     = '0;
    bus.resp_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_req_count", bus.req_count, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_tx_tag", bus.tx_tag, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_resp_status", bus.resp_status, 0);
    chk("rst_err", bus.err_unexp_tag, 0);
    reset = 1'b1;
    tick();

    // T1: single transfer, exact latency
    bus.tx_ready = 1'b1;
    push(32'hA5A5_0001);                       // now cycle N+1
    chk("t1_tx_valid_n1", bus.tx_valid, 0);
    tick();                                    // cycle N+2
    chk("t1_tx_valid_n2", bus.tx_valid, 1);
    chk("t1_tx_data", bus.tx_data, 32'hA5A5_0001);
    chk("t1_tx_tag", bus.tx_tag, 0);
    tick();                                    // WAIT
    bus.rx_valid = 1'b1;
    bus.rx_tag   = 4'd0;
    bus.rx_data  = 32'hDEAD_BEEF;
    exp_resp.push_back({32'hDEAD_BEEF, 2'b00});
    tick();
    bus.rx_valid = 1'b0;
    chk("t1_resp_valid", bus.resp_valid, 1);
    chk("t1_resp_data", bus.resp_data, 32'hDEAD_BEEF);
    chk("t1_resp_status", bus.resp_status, 0);
    chk("t1_err", bus.err_unexp_tag, 0);
    tick();
    chk("t1_resp_hold", bus.resp_data, 32'hDEAD_BEEF);
    bus.resp_ready = 1'b1;
    tick();
    chk("t1_resp_cleared", bus.resp_valid, 0);

    // T2: full buffer, dropped 9th push, order preserved
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.req_valid = 1'b1;
      bus.req_data  = 32'(i);
      exp_tx.push_back(32'(i));
      tick();
    end
    chk("t2_count_full", bus.req_count, 8);
    chk("t2_ready_low", bus.req_ready, 0);
    bus.req_data = 32'd9;
    tick();
    bus.req_valid = 1'b0;
    chk("t2_count_after_drop", bus.req_count, 8);
    chk("t2_tx_held_valid", bus.tx_valid, 1);
    chk("t2_tx_held_data", bus.tx_data, 1);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve(32'h0000_1000 + 32'(i));
    end
    chk("t2_drained", bus.req_count, 0);

    // T3: timeout, then a late response only pulses the error
    push(32'h0000_0333);
    wait_tx();                                 // handshake cycle H
    exp_resp.push_back({32'h0, 2'b01});
    repeat (TO) tick();                        // H+16
    chk("t3_no_resp_early", bus.resp_valid, 0);
    tick();                                    // H+17
    chk("t3_resp_valid", bus.resp_valid, 1);
    chk("t3_resp_status", bus.resp_status, 1);
    chk("t3_resp_data", bus.resp_data, 0);
    tick();
    bus.rx_valid = 1'b1;
    bus.rx_tag   = 4'(model_tag - 4'd1);
    bus.rx_data  = 32'hBAD0_0BAD;
    tick();
    bus.rx_valid = 1'b0;
    chk("t3_late_err", bus.err_unexp_tag, 1);
    chk("t3_late_no_resp", bus.resp_valid, 0);
    tick();
    chk("t3_err_one_cycle", bus.err_unexp_tag, 0);
    chk("t3_no_tx", bus.tx_valid, 0);

    // Matching response in the timeout cycle wins
    push(32'h0000_0444);
    wait_tx();
    repeat (TO) tick();                        // timer at its last value
    bus.rx_valid = 1'b1;
    bus.rx_tag   = model_tag;
    bus.rx_data  = 32'hCAFE_F00D;
    exp_resp.push_back({32'hCAFE_F00D, 2'b00});
    tick();
    bus.rx_valid = 1'b0;
    chk("tb_edge_resp_valid", bus.resp_valid, 1);
    chk("tb_edge_status", bus.resp_status, 0);
    chk("tb_edge_data", bus.resp_data, 32'hCAFE_F00D);
    tick();

    // T6: reset while waiting with three requests buffered
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_data  = 32'h0000_0600 + 32'(i);
      exp_tx.push_back(32'h0000_0600 + 32'(i));
      tick();
    end
    bus.req_valid = 1'b0;
    chk("t6_count_3", bus.req_count, 3);
    chk("t6_waiting", bus.tx_valid, 0);
    reset = 1'b0;
    exp_tx.delete();
    exp_resp.delete();
    model_tag = 4'd0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("t6_count_0", bus.req_count, 0);
    chk("t6_tx_valid", bus.tx_valid, 0);
    chk("t6_resp_valid", bus.resp_valid, 0);
    chk("t6_req_ready", bus.req_ready, 1);

    // T5: 17 transfers for tag wrap, then completion backpressure
    for (int i = 0; i < 16; i++) begin
      push(32'h0000_5000 + 32'(i));
      if (i == 0) begin
        wait_tx();
        chk("t6_first_tag", bus.tx_tag, 0);
      end
      serve(32'h0000_6000 + 32'(i));
    end
    push(32'h0000_5010);
    push(32'h0000_5011);
    wait_tx();
    chk("t5_tag_wrap", bus.tx_tag, 0);
    tick();
    bus.resp_ready = 1'b0;
    bus.rx_valid   = 1'b1;
    bus.rx_tag     = model_tag;
    bus.rx_data    = 32'h7777_5555;
    exp_resp.push_back({32'h7777_5555, 2'b00});
    tick();
    bus.rx_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t5_bp_valid", bus.resp_valid, 1);
      chk("t5_bp_data", bus.resp_data, 32'h7777_5555);
      chk("t5_bp_no_tx", bus.tx_valid, 0);
      tick();
    end
    bus.resp_ready = 1'b1;
    serve(32'h0000_6011);

    // T4: tag mismatch keeps waiting, then the matching response completes
    push(32'h0000_0777);
    wait_tx();
    tick();
    bus.rx_valid = 1'b1;
    bus.rx_tag   = 4'(model_tag + 4'd3);
    bus.rx_data  = 32'hFFFF_0000;
    tick();
    bus.rx_valid = 1'b0;
    chk("t4_err_pulse", bus.err_unexp_tag, 1);
    chk("t4_still_wait", bus.resp_valid, 0);
    tick();
    chk("t4_err_one_cycle", bus.err_unexp_tag, 0);
    chk("t4_still_wait2", bus.resp_valid, 0);
    bus.rx_valid = 1'b1;
    bus.rx_tag   = model_tag;
    bus.rx_data  = 32'h1234_5678;
    exp_resp.push_back({32'h1234_5678, 2'b00});
    tick();
    bus.rx_valid = 1'b0;
    chk("t4_resp_valid", bus.resp_valid, 1);
    chk("t4_resp_data", bus.resp_data, 32'h1234_5678);
    chk("t4_err_quiet", bus.err_unexp_tag, 0);
    repeat (3) tick();

    chk("exp_tx_drained", exp_tx.size(), 0);
    chk("exp_resp_drained", exp_resp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
